// File: rtl/uart_num2ascii.sv
// uart_num2ascii: registered conversion of a 0-15 value to its ASCII hex digit, with an out-of-range flag
module uart_num2ascii #(
    parameter bit         UPPERCASE = 1'b1,
    parameter logic [7:0] BAD_CHAR  = 8'h3F
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] num,
    input  logic       num_valid,
    output logic [7:0] ascii,
    output logic       ascii_valid,
    output logic       err
);
    logic [7:0] w_ascii;
    logic       w_err;
    logic [7:0] r_ascii;
    logic       r_valid;
    logic       r_err;
    always_comb begin
        w_err   = num > 8'd15;
        w_ascii = w_err ? BAD_CHAR
                : num < 8'd10 ? 8'h30 + num
                : (UPPERCASE ? 8'h41 : 8'h61) + (num - 8'd10);
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ascii <= 8'h00;
            r_valid <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_ascii <= w_ascii;
            r_valid <= num_valid;
            r_err   <= w_err;
        end
    end
    assign ascii       = r_ascii;
    assign ascii_valid = r_valid;
    assign err         = r_err;
endmodule

// File: tb/tb_uart_num2ascii.sv
// tb_uart_num2ascii: directed stimulus, per-cycle model compare and literal checks for both letter cases
module tb_uart_num2ascii;
    logic       clk;
    logic       reset;
    logic [7:0] num;
    logic       num_valid;
    logic [7:0] ascii_u, ascii_l;
    logic       valid_u, valid_l, err_u, err_l;
    int         errors = 0;
    int         checks = 0;
    logic [7:0] m_ascii_u, m_ascii_l;
    logic       m_valid, m_err;
    bit         run = 0;

    uart_num2ascii #(.UPPERCASE(1'b1)) dut_u (
        .clk(clk), .reset(reset), .num(num), .num_valid(num_valid),
        .ascii(ascii_u), .ascii_valid(valid_u), .err(err_u)
    );
    uart_num2ascii #(.UPPERCASE(1'b0)) dut_l (
        .clk(clk), .reset(reset), .num(num), .num_valid(num_valid),
        .ascii(ascii_l), .ascii_valid(valid_l), .err(err_l)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    function automatic logic [7:0] conv(input int n, input bit up);
        string digits;
        digits = up ? "0123456789ABCDEF" : "0123456789abcdef";
        return (n > 15) ? 8'h3F : 8'(digits[n]);
    endfunction

    // Reference: outputs are the inputs seen at the last edge, zeroed by reset
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_ascii_u = 0; m_ascii_l = 0; m_valid = 0; m_err = 0;
        end else begin
            m_ascii_u = conv(int'(num), 1'b1);
            m_ascii_l = conv(int'(num), 1'b0);
            m_valid   = num_valid;
            m_err     = num > 15;
        end
    end

    task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%h expected=%h at %0t", name, got, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (run) begin
            chk("model ascii_u", ascii_u, m_ascii_u);
            chk("model ascii_l", ascii_l, m_ascii_l);
            chk("model valid_u", 8'(valid_u), 8'(m_valid));
            chk("model valid_l", 8'(valid_l), 8'(m_valid));
            chk("model err_u", 8'(err_u), 8'(m_err));
            chk("model err_l", 8'(err_l), 8'(m_err));
        end
    end

    task automatic apply(input logic [7:0] n, input logic v);
        @(negedge clk);
        num = n;
        num_valid = v;
        @(posedge clk);
        #1;
    endtask

    task automatic lit(input string name, input logic [7:0] eu, input logic [7:0] el, input logic ev, input logic ee);
        chk({name, " ascii_u"}, ascii_u, eu);
        chk({name, " ascii_l"}, ascii_l, el);
        chk({name, " valid"}, 8'(valid_u), 8'(ev));
        chk({name, " err"}, 8'(err_u), 8'(ee));
    endtask

    initial begin
        reset = 1;
        num = 8'd0;
        num_valid = 1;
        run = 1;
        #1 lit("reset t1", 8'h00, 8'h00, 0, 0);
        num = 8'd200;
        #1 lit("reset t2", 8'h00, 8'h00, 0, 0);
        num = 8'd5;
        #1 lit("reset t3", 8'h00, 8'h00, 0, 0);
        @(posedge clk);
        #1 lit("reset edge", 8'h00, 8'h00, 0, 0);
        @(negedge clk);
        reset = 0;
        for (int i = 0; i < 10; i++) begin
            apply(8'(i), 1'b1);
            lit("digit", 8'h30 + 8'(i), 8'h30 + 8'(i), 1, 0);
        end
        apply(8'd10, 1'b1);  lit("num10", 8'h41, 8'h61, 1, 0);
        apply(8'd15, 1'b1);  lit("num15", 8'h46, 8'h66, 1, 0);
        apply(8'd16, 1'b1);  lit("num16", 8'h3F, 8'h3F, 1, 1);
        apply(8'd255, 1'b1); lit("num255", 8'h3F, 8'h3F, 1, 1);
        apply(8'd9, 1'b1);   lit("num9", 8'h39, 8'h39, 1, 0);
        apply(8'd128, 1'b0); lit("num128 invalid", 8'h3F, 8'h3F, 0, 1);
        apply(8'd3, 1'b1);   lit("v1", 8'h33, 8'h33, 1, 0);
        apply(8'd3, 1'b0);   lit("v0", 8'h33, 8'h33, 0, 0);
        apply(8'd3, 1'b1);   lit("v1b", 8'h33, 8'h33, 1, 0);
        apply(8'd7, 1'b1);   lit("stream7a", 8'h37, 8'h37, 1, 0);
        apply(8'd12, 1'b1);  lit("stream12", 8'h43, 8'h63, 1, 0);
        apply(8'd7, 1'b1);
        #2 reset = 1;
        #1 lit("async reset", 8'h00, 8'h00, 0, 0);
        @(posedge clk);
        #1 lit("held reset", 8'h00, 8'h00, 0, 0);
        @(negedge clk);
        reset = 0;
        @(posedge clk);
        #1 lit("after release", 8'h37, 8'h37, 1, 0);
        apply(8'd11, 1'b1);  lit("num11", 8'h42, 8'h62, 1, 0);
        @(negedge clk);
        #1;
        run = 0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/uart_num2ascii.md
UART_NUM2ASCII -- requirements
Module: uart_num2ascii

Interface
REQ-001 The module SHALL have parameter UPPERCASE, default 1: 1 maps hex letters to 'A'-'F' (0x41-0x46); 0 maps them to 'a'-'f' (0x61-0x66).
REQ-002 The module SHALL have parameter BAD_CHAR, default 8'h3F ('?'): the code output for out-of-range input.
REQ-003 The module SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-004 The module SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 The module SHALL have port num, input, 8 bits: unsigned numeric value to convert.
REQ-006 The module SHALL have port num_valid, input, 1 bit: qualifies num for the valid/error pipeline.
REQ-007 The module SHALL have port ascii, output, 8 bits: registered ASCII code of num.
REQ-008 The module SHALL have port ascii_valid, output, 1 bit: registered copy of num_valid, aligned with ascii.
REQ-009 The module SHALL have port err, output, 1 bit: registered flag, high when the converted num exceeded 15.

Function
REQ-010 On every rising clk edge with reset low, ascii SHALL load the conversion of the current num, regardless of num_valid.
REQ-011 Conversion for num 0-9 SHALL be 0x30 + num ('0'-'9').
REQ-012 Conversion for num 10-15 with UPPERCASE=1 SHALL be 0x41 + (num - 10) ('A'-'F').
REQ-013 Conversion for num 10-15 with UPPERCASE=0 SHALL be 0x61 + (num - 10) ('a'-'f').
REQ-014 Conversion for num 16-255 SHALL be BAD_CHAR, and err SHALL be loaded 1 on the same edge.
REQ-015 For num 0-15, err SHALL be loaded 0.
REQ-016 err SHALL be computed from num alone, independent of num_valid.
REQ-017 ascii_valid SHALL be loaded with num_valid on every edge.
REQ-018 Latency SHALL be exactly one clock cycle from num/num_valid to ascii/ascii_valid/err; no combinational path from inputs to outputs.
REQ-019 Throughput SHALL be one conversion per cycle; there is no backpressure.
REQ-020 Back-to-back input changes SHALL each appear on the outputs in order, one cycle late.
REQ-021 Arithmetic SHALL be 8-bit unsigned; num is never sign-extended; the boundary values are 9->'9', 10->letter, 15->letter, 16->BAD_CHAR, 255->BAD_CHAR.

Reset
REQ-022 While reset is high, ascii SHALL be 8'h00, ascii_valid 0 and err 0, immediately and without waiting for a clk edge.
REQ-023 When reset is asserted mid-stream, in-flight conversions SHALL be discarded.
REQ-024 On the first rising edge after reset deasserts, outputs SHALL reflect the num/num_valid present at that edge.

Verification
REQ-025 The bench SHALL cover: with reset high, outputs ascii=0x00, ascii_valid=0, err=0, even with num changing and no clk edge.
REQ-026 The bench SHALL cover: num stepped 0..9, one value per cycle, with num_valid=1 -> one cycle later ascii = 0x30..0x39 in order, ascii_valid=1, err=0.
REQ-027 The bench SHALL cover: num = 10, 15 with UPPERCASE=1 -> 0x41, 0x46; with UPPERCASE=0 -> 0x61, 0x66; err=0.
REQ-028 The bench SHALL cover: num = 16 and 255 -> ascii=0x3F, err=1; then num=9 -> ascii=0x39, err=0.
REQ-029 The bench SHALL cover: num_valid pattern 1,0,1 with num=3 -> ascii_valid 1,0,1 one cycle later, and ascii=0x33 throughout.
REQ-030 The bench SHALL cover: reset pulsed while num=7 is streaming -> outputs go to 0 asynchronously, then ascii=0x37 on the first edge after release.
